paillier_keygen_batch: RTL
==========================

Name: paillier_keygen_batch

Overview:
- Batch Paillier key-material engine. Holds RAM_SIZE (p,q) prime pairs in internal input RAMs and processes a programmable number of entries per start.
- Each entry yields n = p*q, phi = (p-1)*(q-1) and g = n+1, written into internal output RAMs that the host reads back by address.
- Parametrised, multi-entry successor of the single-pass key_generation_top flow. Adds a programmable entry count, a busy flag, a progress counter and write-collision error reporting.

Parameters:
- DATA_WIDTH, 1024, output word width; must be even. H = DATA_WIDTH/2 is the operand width.
- RAM_ADDR_WIDTH, 5, address width of every internal RAM.
- RAM_SIZE, 2**RAM_ADDR_WIDTH, depth of every internal RAM.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- num_entries  in  RAM_ADDR_WIDTH+1  entries to process from address 0; sampled with start
- busy  out  1  high from the start-sampling edge until done deasserts
- done  out  1  one-cycle completion pulse
- entries_done  out  RAM_ADDR_WIDTH+1  entries written in the current/last batch
- wr_err  out  1  sticky: host write attempted while busy
- p_din  in  DATA_WIDTH  p word; only [H-1:0] used
- p_wr_addr  in  RAM_ADDR_WIDTH  p write address
- p_wr_en  in  1  p write enable
- q_din  in  DATA_WIDTH  q word; only [H-1:0] used
- q_wr_addr  in  RAM_ADDR_WIDTH  q write address
- q_wr_en  in  1  q write enable
- out_rd_addr  in  RAM_ADDR_WIDTH  shared read address for the n/phi/g RAMs
- n_dout  out  DATA_WIDTH  n RAM read data
- phi_dout  out  DATA_WIDTH  phi RAM read data
- g_dout  out  DATA_WIDTH  g RAM read data

Behaviour:
- Reset: busy, done, wr_err and entries_done go to 0; all *_dout go to 0; FSM goes to IDLE. RAM contents are not cleared and are retained across reset.
- Reset mid-batch: operation aborts immediately. The output RAM holds a partial batch; no done pulse.
- Host writes accepted only when busy=0; each RAM is written on the edge where its wr_en=1.
- Any p_wr_en or q_wr_en while busy=1 is dropped and sets wr_err.
- wr_err is cleared only by an accepted start or by reset.
- Read port is registered with 1-cycle latency: *_dout reflects out_rd_addr from the previous edge. Reads are legal at any time, including during busy.
- start while busy is ignored.
- Entry count: neff = min(num_entries, RAM_SIZE). neff = 0 goes straight to DONE.
- FSM states: IDLE, FETCH, LOAD, MUL, WRITE, DONE.
  - IDLE -> FETCH on start. Latches neff, clears entries_done and the index, sets busy.
  - FETCH: presents index to the p/q RAMs -> LOAD.
  - LOAD: captures p[H-1:0] and q[H-1:0]; forms pm1 = (p-1) mod 2^H and qm1 = (q-1) mod 2^H, so p=0 gives 2^H-1 -> MUL.
  - MUL: two radix-2 shift-add multipliers in parallel (p*q and pm1*qm1), one multiplier bit per cycle, exactly H cycles -> WRITE.
  - WRITE: writes n, phi and g = n+1 (full DATA_WIDTH; cannot wrap) to address index; entries_done++, index++. Goes to FETCH if entries_done < neff, else DONE.
  - DONE: done=1 for exactly one cycle, busy drops with it -> IDLE.
- Timing: each entry costs H+3 cycles. With start sampled at edge k0, done is high during the cycle following edge k0 + neff*(H+3). busy falls at the same edge as done.
- Products use the full 2H bits; there is no truncation.

Test Plan (DATA_WIDTH=16, H=8, RAM_ADDR_WIDTH=5):
- p[0]=0xC5, q[0]=0xE3, num_entries=1, start -> done 11 cycles after start edge; n=0xAEAF, phi=0xAD08, g=0xAEB0; entries_done=1.
- p[1]=0x00, q[1]=0x00 and p[2]=0xFF, q[2]=0xFF with upper bits of p_din/q_din = 0xAB, num_entries=3 -> entry 1: n=0x0000, phi=0xFE01, g=0x0001; entry 2: n=0xFE01, phi=0xFC04, g=0xFE02; done at 33 cycles.
- num_entries=40 with all 32 entries loaded -> clamps to 32; done at 352 cycles; entries_done=32; all 32 outputs match the reference model.
- num_entries=0 -> done high in the cycle after the start edge; output RAMs unchanged.
- p_wr_en pulse during busy, plus a second start mid-batch -> p RAM unchanged, wr_err=1 until next start, batch timing unaffected.
- Assert reset at entry 5 of a 10-entry batch -> all outputs 0, no done; entries 0-4 readable; a fresh start then completes normally.

Source files
------------

// File: rtl/paillier_keygen_batch.sv
// Batch Paillier key-material engine: for each stored (p,q) pair computes
// n = p*q, phi = (p-1)*(q-1) and g = n+1 into host-readable output RAMs.
module paillier_keygen_batch #(
    parameter int DATA_WIDTH     = 1024,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int RAM_SIZE       = 2**RAM_ADDR_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [RAM_ADDR_WIDTH:0]   num_entries,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH:0]   entries_done,
    output logic                      wr_err,
    input  logic [DATA_WIDTH-1:0]     p_din,
    input  logic [RAM_ADDR_WIDTH-1:0] p_wr_addr,
    input  logic                      p_wr_en,
    input  logic [DATA_WIDTH-1:0]     q_din,
    input  logic [RAM_ADDR_WIDTH-1:0] q_wr_addr,
    input  logic                      q_wr_en,
    input  logic [RAM_ADDR_WIDTH-1:0] out_rd_addr,
    output logic [DATA_WIDTH-1:0]     n_dout,
    output logic [DATA_WIDTH-1:0]     phi_dout,
    output logic [DATA_WIDTH-1:0]     g_dout
);
    localparam int H  = DATA_WIDTH / 2;
    localparam int CW = $clog2(H) + 1;

    localparam logic [RAM_ADDR_WIDTH:0]   SIZE_W    = (RAM_ADDR_WIDTH+1)'(RAM_SIZE);
    localparam logic [RAM_ADDR_WIDTH:0]   ENTRY_ONE = 1;
    localparam logic [RAM_ADDR_WIDTH-1:0] IDX_ONE   = 1;
    localparam logic [H-1:0]              OP_ONE    = 1;
    localparam logic [DATA_WIDTH-1:0]     WORD_ONE  = 1;
    localparam logic [CW-1:0]             CNT_ONE   = 1;
    localparam logic [CW-1:0]             CNT_LAST  = CW'(H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, MUL, WRITE, DONE} state_t;

    state_t state;

    logic [H-1:0]          p_mem   [RAM_SIZE];
    logic [H-1:0]          q_mem   [RAM_SIZE];
    logic [DATA_WIDTH-1:0] n_mem   [RAM_SIZE];
    logic [DATA_WIDTH-1:0] phi_mem [RAM_SIZE];
    logic [DATA_WIDTH-1:0] g_mem   [RAM_SIZE];

    logic [H-1:0]              p_rd, q_rd, pm1, qm1;
    logic [RAM_ADDR_WIDTH-1:0] index;
    logic [RAM_ADDR_WIDTH:0]   neff, clamped, done_next;
    logic [DATA_WIDTH-1:0]     mcand_n, mcand_phi, acc_n, acc_phi;
    logic [H-1:0]              mplier_n, mplier_phi;
    logic [CW-1:0]             bit_cnt;
    logic                      out_wr;
    logic                      unused_bits;

    assign unused_bits = ^{p_din[DATA_WIDTH-1:H], q_din[DATA_WIDTH-1:H]};
    assign clamped     = (num_entries > SIZE_W) ? SIZE_W : num_entries;
    assign done_next   = entries_done + ENTRY_ONE;
    assign pm1         = p_rd - OP_ONE;
    assign qm1         = q_rd - OP_ONE;
    assign out_wr      = (state == WRITE);

    // Input RAMs: host writes only while idle; read port follows index.
    always_ff @(posedge clock) begin
        if (p_wr_en && !busy) p_mem[p_wr_addr] <= p_din[H-1:0];
        if (q_wr_en && !busy) q_mem[q_wr_addr] <= q_din[H-1:0];
        p_rd <= p_mem[index];
        q_rd <= q_mem[index];
    end

    always_ff @(posedge clock) begin
        if (out_wr) begin
            n_mem[index]   <= acc_n;
            phi_mem[index] <= acc_phi;
            g_mem[index]   <= acc_n + WORD_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_dout   <= '0;
            phi_dout <= '0;
            g_dout   <= '0;
        end else begin
            n_dout   <= n_mem[out_rd_addr];
            phi_dout <= phi_mem[out_rd_addr];
            g_dout   <= g_mem[out_rd_addr];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_err       <= 1'b0;
            entries_done <= '0;
            index        <= '0;
            neff         <= '0;
            mcand_n      <= '0;
            mcand_phi    <= '0;
            acc_n        <= '0;
            acc_phi      <= '0;
            mplier_n     <= '0;
            mplier_phi   <= '0;
            bit_cnt      <= '0;
        end else begin
            if (busy && (p_wr_en || q_wr_en)) wr_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        wr_err       <= 1'b0;
                        busy         <= 1'b1;
                        neff         <= clamped;
                        entries_done <= '0;
                        index        <= '0;
                        if (clamped == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    mcand_n    <= {{H{1'b0}}, p_rd};
                    mcand_phi  <= {{H{1'b0}}, pm1};
                    mplier_n   <= q_rd;
                    mplier_phi <= qm1;
                    acc_n      <= '0;
                    acc_phi    <= '0;
                    bit_cnt    <= '0;
                    state      <= MUL;
                end
                MUL: begin
                    // Full 2H-bit accumulators: partial sums never exceed the final product.
                    if (mplier_n[0])   acc_n   <= acc_n + mcand_n;
                    if (mplier_phi[0]) acc_phi <= acc_phi + mcand_phi;
                    mcand_n    <= mcand_n << 1;
                    mcand_phi  <= mcand_phi << 1;
                    mplier_n   <= mplier_n >> 1;
                    mplier_phi <= mplier_phi >> 1;
                    bit_cnt    <= bit_cnt + CNT_ONE;
                    if (bit_cnt == CNT_LAST) state <= WRITE;
                end
                WRITE: begin
                    entries_done <= done_next;
                    index        <= index + IDX_ONE;
                    if (done_next < neff) begin
                        state <= FETCH;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
